// File: rtl/controlador_imagenes_pkg.sv
// Shared definitions for the picture address scheduler.
// Holds the geometry of the five picture windows (left column, top row,
// width, height and base offset in the unified colour ROM), the rom_sel
// winner codes, the hit-vector bit positions and the blink FSM states.
package controlador_imagenes_pkg;

    localparam int unsigned HORA_XL     = 256;
    localparam int unsigned HORA_YT     = 0;
    localparam int unsigned HORA_W      = 128;
    localparam int unsigned HORA_H      = 64;
    localparam int unsigned HORA_BASE   = 0;

    localparam int unsigned TIMER_XL    = 416;
    localparam int unsigned TIMER_YT    = 416;
    localparam int unsigned TIMER_W     = 80;
    localparam int unsigned TIMER_H     = 32;
    localparam int unsigned TIMER_BASE  = 8192;

    localparam int unsigned RING_XL     = 512;
    localparam int unsigned RING_YT     = 128;
    localparam int unsigned RING_W      = 128;
    localparam int unsigned RING_H      = 64;
    localparam int unsigned RING_BASE   = 10752;

    localparam int unsigned RBALL_XL    = 544;
    localparam int unsigned RBALL_YT    = 64;
    localparam int unsigned RBALL_W     = 48;
    localparam int unsigned RBALL_H     = 48;
    localparam int unsigned RBALL_BASE  = 18944;

    localparam int unsigned LOGO_XL     = 0;
    localparam int unsigned LOGO_YT     = 0;
    localparam int unsigned LOGO_W      = 128;
    localparam int unsigned LOGO_H      = 16;
    localparam int unsigned LOGO_BASE   = 21248;

    // Bit positions inside the registered hit vector.
    localparam int unsigned HIT_HORA    = 0;
    localparam int unsigned HIT_TIMER   = 1;
    localparam int unsigned HIT_RING    = 2;
    localparam int unsigned HIT_RBALL   = 3;
    localparam int unsigned HIT_LOGO    = 4;

    typedef enum logic [2:0] {
        SEL_NONE     = 3'd0,
        SEL_HORA     = 3'd1,
        SEL_TIMER    = 3'd2,
        SEL_RING     = 3'd3,
        SEL_RINGBALL = 3'd4,
        SEL_LOGO     = 3'd5
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } blink_st_e;

endpackage

// File: rtl/controlador_imagenes_win_addr_calc.sv
// win_addr_calc: combinational window hit test for one picture window.
//   pixel_x, pixel_y : current pixel position
//   hit              : pixel lies inside [XL, XL+W) x [YT, YT+H)
//   dx, dy           : pixel offset from the window's top-left corner
//                      (only meaningful when hit=1)
module win_addr_calc #(
    parameter int unsigned XL = 0,
    parameter int unsigned YT = 0,
    parameter int unsigned W  = 1,
    parameter int unsigned H  = 1
) (
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic       hit,
    output logic [6:0] dx,
    output logic [5:0] dy
);
    logic [10:0] dx_full;
    logic [10:0] dy_full;

    // One extra bit makes a pixel left of/above the window wrap to a large
    // value, so a single unsigned "< size" compare covers both bounds.
    always_comb begin
        dx_full = {1'b0, pixel_x} - 11'(XL);
        dy_full = {1'b0, pixel_y} - 11'(YT);
        hit     = (dx_full < 11'(W)) && (dy_full < 11'(H));
        dx      = dx_full[6:0];
        dy      = dy_full[5:0];
    end

endmodule

// File: rtl/controlador_imagenes.sv
// controlador_imagenes: picture address scheduler for the colour ROM.
// Picks, per pixel, the highest-priority picture window covering it and
// produces that window's ROM address two pix_ticks later. A blink FSM
// gates the ring/ringball windows while the alarm is ringing.
//   clk, reset   : clock, asynchronous active-high reset
//   pix_tick     : pixel enable, pipeline and FSM advance only when 1
//   video_on     : visible-region flag
//   pixel_x/y    : current pixel position
//   ring_en      : alarm ringing request (level)
//   rom_addr     : unified ROM address
//   rom_sel      : winning window (0 none,1 hora,2 timer,3 ring,4 ringball,5 logo)
//   pic_on       : a window won and video was on, aligned with rom_addr
//   video_on_d   : video_on delayed to match rom_addr
//   blink_on     : FSM is in the ON phase
module controlador_imagenes
    import controlador_imagenes_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned ADDR_W       = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pix_tick,
    input  logic              video_on,
    input  logic [9:0]        pixel_x,
    input  logic [9:0]        pixel_y,
    input  logic              ring_en,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [2:0]        rom_sel,
    output logic              pic_on,
    output logic              video_on_d,
    output logic              blink_on
);
    logic [4:0] win_hit;
    logic [6:0] win_dx [5];
    logic [5:0] win_dy [5];

    win_addr_calc #(.XL(HORA_XL),  .YT(HORA_YT),  .W(HORA_W),  .H(HORA_H))  u_hora
        (.pixel_x(pixel_x), .pixel_y(pixel_y), .hit(win_hit[HIT_HORA]),  .dx(win_dx[HIT_HORA]),  .dy(win_dy[HIT_HORA]));
    win_addr_calc #(.XL(TIMER_XL), .YT(TIMER_YT), .W(TIMER_W), .H(TIMER_H)) u_timer
        (.pixel_x(pixel_x), .pixel_y(pixel_y), .hit(win_hit[HIT_TIMER]), .dx(win_dx[HIT_TIMER]), .dy(win_dy[HIT_TIMER]));
    win_addr_calc #(.XL(RING_XL),  .YT(RING_YT),  .W(RING_W),  .H(RING_H))  u_ring
        (.pixel_x(pixel_x), .pixel_y(pixel_y), .hit(win_hit[HIT_RING]),  .dx(win_dx[HIT_RING]),  .dy(win_dy[HIT_RING]));
    win_addr_calc #(.XL(RBALL_XL), .YT(RBALL_YT), .W(RBALL_W), .H(RBALL_H)) u_rball
        (.pixel_x(pixel_x), .pixel_y(pixel_y), .hit(win_hit[HIT_RBALL]), .dx(win_dx[HIT_RBALL]), .dy(win_dy[HIT_RBALL]));
    win_addr_calc #(.XL(LOGO_XL),  .YT(LOGO_YT),  .W(LOGO_W),  .H(LOGO_H))  u_logo
        (.pixel_x(pixel_x), .pixel_y(pixel_y), .hit(win_hit[HIT_LOGO]),  .dx(win_dx[HIT_LOGO]),  .dy(win_dy[HIT_LOGO]));

    // Stage 1 / stage 2 / FSM state
    logic [4:0]        hit_q,      hit_d;
    logic [6:0]        dx_q,       dx_d;
    logic [5:0]        dy_q,       dy_d;
    logic              vid_s1_q,   vid_s1_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    sel_e              rom_sel_q,  rom_sel_d;
    logic              pic_on_q,   pic_on_d;
    logic              vid_s2_q,   vid_s2_d;
    blink_st_e         state_q,    state_d;
    logic [7:0]        frame_cnt_q, frame_cnt_d;

    logic              frame_start;
    logic [4:0]        hit_gated;
    logic [ADDR_W-1:0] dx_w, dy_w;

    assign blink_on    = (state_q == ST_ON);
    assign frame_start = pix_tick && (pixel_x == '0) && (pixel_y == '0);

    // Stage 1: gate ring/ringball by blink, keep the winner's offsets.
    always_comb begin
        hit_gated            = win_hit;
        hit_gated[HIT_RING]  = win_hit[HIT_RING]  && blink_on;
        hit_gated[HIT_RBALL] = win_hit[HIT_RBALL] && blink_on;
        hit_d    = hit_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        vid_s1_d = vid_s1_q;
        if (pix_tick) begin
            hit_d    = hit_gated;
            vid_s1_d = video_on;
            dx_d     = '0;
            dy_d     = '0;
            for (int i = 4; i >= 0; i--) begin
                if (hit_gated[i]) begin
                    dx_d = win_dx[i];
                    dy_d = win_dy[i];
                end
            end
        end
    end

    // Stage 2: priority encode and form base + dy*W + dx with shifts only.
    always_comb begin
        dx_w       = ADDR_W'(dx_q);
        dy_w       = ADDR_W'(dy_q);
        rom_addr_d = rom_addr_q;
        rom_sel_d  = rom_sel_q;
        pic_on_d   = pic_on_q;
        vid_s2_d   = vid_s2_q;
        if (pix_tick) begin
            rom_addr_d = '0;
            rom_sel_d  = SEL_NONE;
            vid_s2_d   = vid_s1_q;
            if (vid_s1_q) begin
                if (hit_q[HIT_HORA]) begin
                    rom_sel_d  = SEL_HORA;
                    rom_addr_d = ADDR_W'(HORA_BASE) + (dy_w << 7) + dx_w;
                end else if (hit_q[HIT_TIMER]) begin
                    rom_sel_d  = SEL_TIMER;
                    rom_addr_d = ADDR_W'(TIMER_BASE) + (dy_w << 6) + (dy_w << 4) + dx_w;
                end else if (hit_q[HIT_RING]) begin
                    rom_sel_d  = SEL_RING;
                    rom_addr_d = ADDR_W'(RING_BASE) + (dy_w << 7) + dx_w;
                end else if (hit_q[HIT_RBALL]) begin
                    rom_sel_d  = SEL_RINGBALL;
                    rom_addr_d = ADDR_W'(RBALL_BASE) + (dy_w << 5) + (dy_w << 4) + dx_w;
                end else if (hit_q[HIT_LOGO]) begin
                    rom_sel_d  = SEL_LOGO;
                    rom_addr_d = ADDR_W'(LOGO_BASE) + (dy_w << 7) + dx_w;
                end
            end
            pic_on_d = (rom_sel_d != SEL_NONE);
        end
    end

    // Blink FSM: all transitions happen on frame_start only.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        if (frame_start) begin
            case (state_q)
                ST_IDLE: begin
                    if (ring_en) begin
                        state_d     = ST_ON;
                        frame_cnt_d = '0;
                    end
                end
                ST_ON, ST_OFF: begin
                    if (!ring_en) begin
                        state_d     = ST_IDLE;
                        frame_cnt_d = '0;
                    end else if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                        state_d     = (state_q == ST_ON) ? ST_OFF : ST_ON;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_q       <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            vid_s1_q    <= 1'b0;
            rom_addr_q  <= '0;
            rom_sel_q   <= SEL_NONE;
            pic_on_q    <= 1'b0;
            vid_s2_q    <= 1'b0;
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
        end else begin
            hit_q       <= hit_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            vid_s1_q    <= vid_s1_d;
            rom_addr_q  <= rom_addr_d;
            rom_sel_q   <= rom_sel_d;
            pic_on_q    <= pic_on_d;
            vid_s2_q    <= vid_s2_d;
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign rom_sel    = rom_sel_q;
    assign pic_on     = pic_on_q;
    assign video_on_d = vid_s2_q;

endmodule
